tft_seq_player: RTL and testbench

//   Parametrised command-sequence player for the TFT SPI link. Fetches 10-bit opcodes

---
 rtl/tft_seq_player.sv | 201 ++++++++++++++++++++
 tb/tb_tft_seq_player.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tft_seq_player.sv
// Command-sequence player for the TFT SPI link: walks 10-bit opcodes in a
// sync ROM from start_addr and drives the byte transmitter.
// Ports:
//   clk, rst               clock, async active-high reset
//   start, start_addr      run request (taken only when idle) and first entry
//   rom_addr, rom_data     sync ROM read port, data one cycle after address
//   tft_busy               transmitter busy flag
//   tft_transmit/dc/data   one-cycle send strobe with byte and D/C select
//   busy, done             sequence running / last sequence finished (sticky)
module tft_seq_player #(
    parameter int ADDR_W     = 7,
    parameter int CLK_PER_MS = 50000,
    parameter int PRESC_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [9:0]        rom_data,
    input  logic              tft_busy,
    output logic              tft_transmit,
    output logic              tft_dc,
    output logic [7:0]        tft_data,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_SEND,
        S_ACK, S_DRAIN, S_DELAY, S_DONE
    } state_t;

    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_PER_MS - 1);
    localparam logic [ADDR_W-1:0]  ADDR_LAST = '1;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                xmit_q, xmit_d;
    logic                dc_q, dc_d;
    logic [7:0]          data_q, data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [6:0]          cnt_q, cnt_d;
    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic [7:0]          ms_q, ms_d;
    // Decoded byte waits here so tft_data only changes on the SEND edge.
    logic [7:0]          arg_q, arg_d;
    logic                isdat_q, isdat_d;
    logic                adv;

    logic [1:0] op;
    logic [7:0] arg;
    assign op  = rom_data[9:8];
    assign arg = rom_data[7:0];

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        xmit_d  = 1'b0;
        dc_d    = dc_q;
        data_d  = data_q;
        busy_d  = busy_q;
        done_d  = done_q;
        cnt_d   = cnt_q;
        presc_d = presc_q;
        ms_d    = ms_q;
        arg_d   = arg_q;
        isdat_d = isdat_q;
        adv     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start && !busy_q) begin
                    addr_d  = start_addr;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                unique case (op)
                    2'b00, 2'b01: begin
                        arg_d   = arg;
                        isdat_d = op[0];
                        // A pending repeat count only applies to DATA.
                        if (!op[0]) cnt_d = '0;
                        state_d = S_SEND;
                    end
                    2'b10: begin
                        cnt_d = '0;
                        if (arg != 8'd0) begin
                            ms_d    = arg;
                            presc_d = '0;
                            state_d = S_DELAY;
                        end else begin
                            adv = 1'b1;
                        end
                    end
                    2'b11: begin
                        if (arg[7]) begin
                            state_d = S_DONE;
                        end else begin
                            cnt_d = arg[6:0];
                            adv   = 1'b1;
                        end
                    end
                endcase
            end
            S_SEND: begin
                if (!tft_busy) begin
                    xmit_d  = 1'b1;
                    dc_d    = isdat_q;
                    data_d  = arg_q;
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                if (tft_busy) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (!tft_busy) begin
                    if (cnt_q != 7'd0) begin
                        cnt_d   = cnt_q - 7'd1;
                        state_d = S_SEND;
                    end else begin
                        adv = 1'b1;
                    end
                end
            end
            S_DELAY: begin
                if (presc_q == PRESC_MAX) begin
                    presc_d = '0;
                    if (ms_q == 8'd1) begin
                        ms_d = 8'd0;
                        adv  = 1'b1;
                    end else begin
                        ms_d = ms_q - 8'd1;
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Running off the top of the ROM ends the sequence; no wrap.
        if (adv) begin
            if (addr_q == ADDR_LAST) begin
                state_d = S_DONE;
            end else begin
                addr_d  = addr_q + 1'b1;
                state_d = S_FETCH;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            xmit_q  <= 1'b0;
            dc_q    <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            presc_q <= '0;
            ms_q    <= '0;
            arg_q   <= '0;
            isdat_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            xmit_q  <= xmit_d;
            dc_q    <= dc_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            presc_q <= presc_d;
            ms_q    <= ms_d;
            arg_q   <= arg_d;
            isdat_q <= isdat_d;
        end
    end

    assign rom_addr     = addr_q;
    assign tft_transmit = xmit_q;
    assign tft_dc       = dc_q;
    assign tft_data     = data_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_tft_seq_player.sv
// Bench for tft_seq_player: table of ROM sequences checked through a
// pulse scoreboard, plus reset and start-while-busy corner cases.
module tb_tft_seq_player;

    localparam int AW = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [AW-1:0] rom_addr;
    logic [9:0]    rom_data;
    logic          tft_busy;
    logic          tft_transmit;
    logic          tft_dc;
    logic [7:0]    tft_data;
    logic          busy;
    logic          done;

    logic [9:0] rom [128];

    typedef struct packed {
        logic [8:0] b;
        logic [7:0] g;
    } exp_t;

    typedef struct packed {
        logic [6:0]      addr;
        logic [6:0]      last;
        logic [2:0]      n;
        logic [4:0][8:0] b;
        logic [4:0][7:0] g;
    } vec_t;

    exp_t q[$];
    vec_t tv [8];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int start_cyc = 0;
    int fall_cyc = 0;
    int bcnt = 0;
    bit pend = 1'b0;

    tft_seq_player #(
        .ADDR_W(AW),
        .CLK_PER_MS(4),
        .PRESC_W(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .start_addr(start_addr),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .tft_busy(tft_busy),
        .tft_transmit(tft_transmit),
        .tft_dc(tft_dc),
        .tft_data(tft_data),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // One cycle: score any pulse, then advance the transmitter model
    // (busy for three cycles after each pulse).
    task automatic tick();
        exp_t e;
        int   rc;
        @(negedge clk);
        cyc++;
        if (tft_transmit) begin
            chk("busy_between_pulses", 32'(pend), 32'd0);
            pend = 1'b1;
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pulse: got %0h want none",
                         {tft_dc, tft_data});
            end else begin
                e = q.pop_front();
                chk("pulse_byte", 32'({tft_dc, tft_data}), 32'(e.b));
                if (e.g != 8'd0) begin
                    rc = (fall_cyc > start_cyc) ? fall_cyc : start_cyc;
                    chk("pulse_gap", 32'(cyc - rc), 32'(e.g));
                end
            end
            bcnt = 3;
        end else if (bcnt > 0) begin
            bcnt--;
            if (bcnt == 0) begin
                fall_cyc = cyc;
                pend = 1'b0;
            end
        end
        tft_busy = (bcnt != 0);
    endtask

    task automatic push(input logic [8:0] b, input logic [7:0] g);
        exp_t e;
        e.b = b;
        e.g = g;
        q.push_back(e);
    endtask

    task automatic run_start(input logic [6:0] a);
        start_addr = a;
        start = 1'b1;
        start_cyc = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        for (int i = 0; i < lim; i++) begin
            if (done) break;
            tick();
        end
        chk("done_reached", 32'(done), 32'd1);
    endtask

    task automatic end_checks(input logic [6:0] last);
        repeat (6) tick();
        chk("sb_empty", 32'(q.size()), 32'd0);
        chk("busy_end", 32'(busy), 32'd0);
        chk("done_end", 32'(done), 32'd1);
        chk("rom_addr_end", 32'(rom_addr), 32'(last));
        q.delete();
    endtask

    task automatic rst_mid(input string nm);
        #1 rst = 1'b1;
        #1 chk(nm, 32'({rom_addr, tft_transmit, tft_dc, tft_data, busy, done}),
               32'd0);
        q.delete();
        tick();
        rst = 1'b0;
        repeat (30) tick();
        chk("idle_after_rst", 32'({busy, done}), 32'd0);
    endtask

    task automatic set_vec(input int i, input logic [6:0] a,
                           input logic [6:0] last, input int n,
                           input logic [8:0] b0, input logic [8:0] b1,
                           input logic [8:0] b2, input logic [8:0] b3,
                           input logic [8:0] b4, input logic [7:0] g0,
                           input logic [7:0] g1, input logic [7:0] g2,
                           input logic [7:0] g3, input logic [7:0] g4);
        tv[i].addr = a;
        tv[i].last = last;
        tv[i].n    = 3'(n);
        tv[i].b    = {b4, b3, b2, b1, b0};
        tv[i].g    = {g4, g3, g2, g1, g0};
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        start_addr = '0;
        tft_busy = 1'b0;
        for (int i = 0; i < 128; i++) rom[i] = 10'h380;
        rom[0]   = 10'h02A; rom[1]   = 10'h100;
        rom[2]   = 10'h110; rom[3]   = 10'h380;
        rom[8]   = 10'h011; rom[9]   = 10'h203;
        rom[10]  = 10'h029; rom[11]  = 10'h380;
        rom[16]  = 10'h304; rom[17]  = 10'h1FF; rom[18] = 10'h380;
        rom[24]  = 10'h011; rom[25]  = 10'h200;
        rom[26]  = 10'h029; rom[27]  = 10'h380;
        rom[32]  = 10'h302; rom[33]  = 10'h055;
        rom[34]  = 10'h166; rom[35]  = 10'h380;
        rom[40]  = 10'h201; rom[41]  = 10'h177; rom[42] = 10'h380;
        rom[48]  = 10'h300; rom[49]  = 10'h133; rom[50] = 10'h380;
        rom[125] = 10'h0A1; rom[126] = 10'h0A2; rom[127] = 10'h0A3;

        // addr, last entry, pulses, {dc,data} x5, gap to previous event x5
        set_vec(0, 7'd0,   7'd3,   3, 9'h02A, 9'h100, 9'h110, 0, 0,
                4, 4, 4, 0, 0);
        set_vec(1, 7'd8,   7'd11,  2, 9'h011, 9'h029, 0, 0, 0,
                4, 18, 0, 0, 0);
        set_vec(2, 7'd16,  7'd18,  5, 9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF,
                9'h1FF, 6, 2, 2, 2, 2);
        set_vec(3, 7'h7D,  7'h7F,  3, 9'h0A1, 9'h0A2, 9'h0A3, 0, 0,
                4, 4, 4, 0, 0);
        set_vec(4, 7'd24,  7'd27,  2, 9'h011, 9'h029, 0, 0, 0,
                4, 6, 0, 0, 0);
        set_vec(5, 7'd32,  7'd35,  2, 9'h055, 9'h166, 0, 0, 0,
                6, 4, 0, 0, 0);
        set_vec(6, 7'd40,  7'd42,  1, 9'h177, 0, 0, 0, 0,
                10, 0, 0, 0, 0);
        set_vec(7, 7'd48,  7'd50,  1, 9'h133, 0, 0, 0, 0,
                6, 0, 0, 0, 0);

        repeat (2) tick();
        chk("reset_state",
            32'({rom_addr, tft_transmit, tft_dc, tft_data, busy, done}), 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < int'(tv[i].n); k++) push(tv[i].b[k], tv[i].g[k]);
            run_start(tv[i].addr);
            chk("busy_after_start", 32'(busy), 32'd1);
            wait_done(200);
            end_checks(tv[i].last);
        end

        // Reset while waiting in DELAY.
        push(9'h011, 8'd4);
        run_start(7'd8);
        for (int i = 0; i < 40 && q.size() != 0; i++) tick();
        chk("pre_delay_pulse", 32'(q.size()), 32'd0);
        repeat (8) tick();
        rst_mid("rst_in_delay");

        // Reset in the cycle the strobe is high (ACK state).
        push(9'h02A, 8'd4);
        run_start(7'd0);
        for (int i = 0; i < 40 && q.size() != 0; i++) tick();
        chk("pre_ack_pulse", 32'(q.size()), 32'd0);
        rst_mid("rst_in_ack");

        // Clean rerun after reset.
        push(9'h02A, 8'd4);
        push(9'h100, 8'd4);
        push(9'h110, 8'd4);
        run_start(7'd0);
        wait_done(200);
        end_checks(7'd3);

        // Start while busy is ignored; start right after done is taken.
        push(9'h02A, 8'd4);
        push(9'h100, 8'd4);
        push(9'h110, 8'd4);
        run_start(7'd0);
        for (int i = 0; i < 40 && q.size() > 2; i++) tick();
        start_addr = 7'd8;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(200);
        chk("ignored_start_sb", 32'(q.size()), 32'd0);
        chk("ignored_start_addr", 32'(rom_addr), 32'd3);
        push(9'h133, 8'd6);
        run_start(7'd48);
        chk("done_cleared", 32'(done), 32'd0);
        chk("busy_restart", 32'(busy), 32'd1);
        wait_done(200);
        end_checks(7'd50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
